// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds memory geometry and the loader FSM state encoding.
package mips_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int WORD_W      = 32;
  localparam int BYTES_PW    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write-port bundle of the loader.
// master: loader side; slave: stream source / memory side.
interface imem_loader_if;
  import mips_pkg::*;

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   mem_we;
  logic [IMEM_ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0]      mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Packs 4 accepted bytes big-endian into one word.
// Ports: clk, rst, clear, byte_en, in_byte -> word, word_full.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  // Shifting left makes the first byte land in the MSB.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[WORD_W-9:0], in_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign word      = sr_q;
  assign word_full = byte_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory, one word per 4 bytes.
// Ports: clk, rst, start, word_count, bus (stream + imem), busy, cpu_hold, done, err.
module imem_loader
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [8:0]    word_count,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  loader_state_t          state_q, state_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]             words_q, words_d;
  logic [8:0]             count_q, count_d;
  logic                   err_q, err_d;

  logic              clear;
  logic              byte_en;
  logic              word_full;
  logic [WORD_W-1:0] word;

  assign byte_en = (state_q == RECV) && bus.in_valid;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .byte_en   (byte_en),
    .in_byte   (bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    words_d = words_q;
    count_d = count_q;
    err_d   = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != 9'd0) begin
            count_d = word_count;
            addr_d  = '0;
            words_d = '0;
            clear   = 1'b1;
            state_d = RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 9'd1;
        if (words_q + 9'd1 == count_q) state_d = DONE;
        else                           state_d = RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      words_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == RECV);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = word;
  assign busy          = (state_q == RECV) || (state_q == WRITE);
  assign cpu_hold      = busy;
  assign done          = (state_q == DONE);
  assign err           = err_q;

endmodule
